pe: RTL and testbench

- One processing element of a linear systolic Smith-Waterman local-alignment array. Each PE owns one read base, which is one DP matrix row.
- Reference bases stream past the array one PE per cycle. Each valid cycle the PE computes one cell H(i,j), a 2-bit traceback direction, and forwards up/diag scores to the next PE.
- PE0 is driven with zeros on in1_up/in2_diag; PE k is driven by PE k-1's out1/out2.

---
 rtl/pe_pkg.sv | 43 ++++
 rtl/pe.sv | 98 +++++++++
 tb/tb_pe.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// Shared encodings and helpers for the Smith-Waterman systolic processing element.
// Holds base/direction codes, default scores and the max3-with-direction selector.
package pe_pkg;

    localparam logic [1:0] BASE_A = 2'd0;
    localparam logic [1:0] BASE_C = 2'd1;
    localparam logic [1:0] BASE_G = 2'd2;
    localparam logic [1:0] BASE_T = 2'd3;

    localparam logic [1:0] DIR_NONE = 2'd0;
    localparam logic [1:0] DIR_DIAG = 2'd1;
    localparam logic [1:0] DIR_UP   = 2'd2;
    localparam logic [1:0] DIR_LEFT = 2'd3;

    localparam int DEF_SCORE_W     = 8;
    localparam int DEF_MATCH_SC    = 2;
    localparam int DEF_MISMATCH_SC = -1;
    localparam int DEF_GAP_SC      = -1;

    typedef struct packed {
        logic signed [31:0] best;
        logic [1:0]         dir;
    } max3_t;

    // Ties resolve diag over up over left so traceback prefers the diagonal path.
    function automatic max3_t max3(input logic signed [31:0] d,
                                   input logic signed [31:0] u,
                                   input logic signed [31:0] l);
        max3_t r;
        if (d >= u && d >= l) begin
            r.best = d;
            r.dir  = DIR_DIAG;
        end else if (u >= l) begin
            r.best = u;
            r.dir  = DIR_UP;
        end else begin
            r.best = l;
            r.dir  = DIR_LEFT;
        end
        return r;
    endfunction

endpackage

// File: rtl/pe.sv
// One Smith-Waterman PE: owns one read base (one DP row) and computes one cell
// per valid reference base, forwarding H(i,j) and H(i,j-1) to the next PE.
module pe
    import pe_pkg::*;
#(
    parameter int SCORE_W     = DEF_SCORE_W,
    parameter int MATCH_SC    = DEF_MATCH_SC,
    parameter int MISMATCH_SC = DEF_MISMATCH_SC,
    parameter int GAP_SC      = DEF_GAP_SC
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      compute_en,
    input  logic                      clear_en,
    input  logic                      in_valid,
    input  logic                      read_load_en,
    input  logic [1:0]                read_base_in,
    input  logic [1:0]                ref_base_in,
    input  logic signed [SCORE_W-1:0] in1_up,
    input  logic signed [SCORE_W-1:0] in2_diag,
    output logic signed [SCORE_W-1:0] out1,
    output logic signed [SCORE_W-1:0] out2,
    output logic                      out_valid,
    output logic [1:0]                dir,
    output logic signed [SCORE_W-1:0] pe_score
);

    localparam int EW    = SCORE_W + 1;
    localparam int H_MAX = (2 ** (SCORE_W - 1)) - 1;

    logic [1:0]                read_q;
    logic signed [SCORE_W-1:0] h_cur_q;
    logic signed [SCORE_W-1:0] h_prev_q;
    logic [1:0]                dir_q;
    logic                      valid_q;

    logic signed [EW-1:0]      score_s;
    logic signed [EW-1:0]      diag_s;
    logic signed [EW-1:0]      up_s;
    logic signed [EW-1:0]      left_s;
    max3_t                     pick;
    logic signed [31:0]        best_s;
    logic signed [SCORE_W-1:0] h_d;
    logic [1:0]                dir_d;
    logic                      fire;

    assign fire = compute_en && in_valid && !clear_en;

    // One extra bit of headroom keeps d/u/l exact before clamping to [0, H_MAX].
    always_comb begin
        score_s = (read_q == ref_base_in) ? EW'(MATCH_SC) : EW'(MISMATCH_SC);
        diag_s  = EW'(in2_diag) + score_s;
        up_s    = EW'(in1_up) + EW'(GAP_SC);
        left_s  = EW'(h_cur_q) + EW'(GAP_SC);
        pick    = max3(32'(diag_s), 32'(up_s), 32'(left_s));
        best_s  = pick.best;
        h_d     = '0;
        dir_d   = DIR_NONE;
        if (best_s > 0) begin
            dir_d = pick.dir;
            h_d   = (best_s > H_MAX) ? SCORE_W'(H_MAX) : SCORE_W'(best_s);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_q   <= '0;
            h_cur_q  <= '0;
            h_prev_q <= '0;
            dir_q    <= DIR_NONE;
            valid_q  <= 1'b0;
        end else begin
            if (read_load_en) begin
                read_q <= read_base_in;
            end
            if (clear_en) begin
                h_cur_q  <= '0;
                h_prev_q <= '0;
                dir_q    <= DIR_NONE;
                valid_q  <= 1'b0;
            end else if (fire) begin
                h_prev_q <= h_cur_q;
                h_cur_q  <= h_d;
                dir_q    <= dir_d;
                valid_q  <= 1'b1;
            end else begin
                valid_q  <= 1'b0;
            end
        end
    end

    assign out1      = h_cur_q;
    assign out2      = h_prev_q;
    assign pe_score  = h_cur_q;
    assign dir       = dir_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_pe.sv
// Scoreboard bench for pe: expected cells are queued when driven and compared
// when out_valid appears; a small reference model covers cells not tabulated.
module tb_pe;

    logic              clk;
    logic              rst_n;
    logic              compute_en;
    logic              clear_en;
    logic              in_valid;
    logic              read_load_en;
    logic [1:0]        read_base_in;
    logic [1:0]        ref_base_in;
    logic signed [7:0] in1_up;
    logic signed [7:0] in2_diag;
    logic signed [7:0] out1;
    logic signed [7:0] out2;
    logic              out_valid;
    logic [1:0]        dir;
    logic signed [7:0] pe_score;

    pe dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .compute_en   (compute_en),
        .clear_en     (clear_en),
        .in_valid     (in_valid),
        .read_load_en (read_load_en),
        .read_base_in (read_base_in),
        .ref_base_in  (ref_base_in),
        .in1_up       (in1_up),
        .in2_diag     (in2_diag),
        .out1         (out1),
        .out2         (out2),
        .out_valid    (out_valid),
        .dir          (dir),
        .pe_score     (pe_score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int h;
        int prev;
        int dr;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   m_read   = 0;
    int   m_cur    = 0;
    int   m_prev   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic void ref_cell(input int rd, input int rf, input int up, input int dg,
                                     input int hc, output int h, output int dr);
        int s;
        int best;
        s    = (rd == rf) ? 2 : -1;
        best = dg + s;
        dr   = 1;
        if (up - 1 > best) begin best = up - 1; dr = 2; end
        if (hc - 1 > best) begin best = hc - 1; dr = 3; end
        if (best <= 0) begin
            h  = 0;
            dr = 0;
        end else begin
            h = (best > 127) ? 127 : best;
        end
    endfunction

    // Drive one cycle of stimulus; exp_h/exp_dir of -1 fall back to the model.
    task automatic step(input bit ce, input bit v, input int rf, input int up, input int dg,
                        input int exp_h, input int exp_dir);
        int h;
        int dr;
        exp_t e;
        @(negedge clk);
        compute_en   = ce;
        in_valid     = v;
        clear_en     = 1'b0;
        read_load_en = 1'b0;
        ref_base_in  = 2'(rf);
        in1_up       = 8'(up);
        in2_diag     = 8'(dg);
        if (ce && v) begin
            ref_cell(m_read, rf, up, dg, m_cur, h, dr);
            if (exp_h >= 0) h = exp_h;
            if (exp_dir >= 0) dr = exp_dir;
            e.h = h; e.prev = m_cur; e.dr = dr; e.cyc = cyc;
            sb.push_back(e);
            m_prev = m_cur;
            m_cur  = h;
        end
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 0, 0, 0, -1, -1);
    endtask

    task automatic load_read(input int b);
        @(negedge clk);
        in_valid     = 1'b0;
        clear_en     = 1'b0;
        read_load_en = 1'b1;
        read_base_in = 2'(b);
        m_read       = b;
    endtask

    // Clear with an otherwise-firing compute present: clear must win.
    task automatic do_clear();
        @(negedge clk);
        read_load_en = 1'b0;
        compute_en   = 1'b1;
        in_valid     = 1'b1;
        clear_en     = 1'b1;
        m_cur  = 0;
        m_prev = 0;
        @(negedge clk);
        clear_en = 1'b0;
        in_valid = 1'b0;
        chk("clear_valid", int'(out_valid), 0);
        chk("clear_h", int'(out1), 0);
        chk("clear_prev", int'(out2), 0);
        chk("clear_dir", int'(dir), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out1", int'(out1), e.h);
                    chk("out2", int'(out2), e.prev);
                    chk("dir", int'(dir), e.dr);
                    chk("pe_score", int'(pe_score), e.h);
                end
            end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
                chk("latency_valid", 0, 1);
                void'(sb.pop_front());
            end
        end
    end

    int reads[5]      = '{2, 0, 2, 1, 3};
    int refs[5]       = '{0, 2, 1, 2, 3};
    int rows[5][5]    = '{'{0, 2, 1, 2, 1}, '{2, 1, 1, 1, 1}, '{1, 4, 3, 3, 2},
                          '{0, 3, 6, 5, 4}, '{0, 2, 5, 5, 7}};
    int row_dirs[2][5] = '{'{0, 1, 3, 1, 3}, '{1, 2, 1, 2, 1}};

    task automatic run_row(input int r, input bit stall);
        int up;
        int dg;
        do_clear();
        for (int j = 0; j < 5; j++) begin
            up = (r == 0) ? 0 : rows[r-1][j];
            dg = (r == 0 || j == 0) ? 0 : rows[r-1][j-1];
            if (stall && j == 2) begin
                step(1'b1, 1'b0, refs[j], up, dg, -1, -1);
                step(1'b0, 1'b1, refs[j], up, dg, -1, -1);
            end
            step(1'b1, 1'b1, refs[j], up, dg, rows[r][j], (r < 2) ? row_dirs[r][j] : -1);
        end
        idle();
    endtask

    initial begin
        rst_n = 1'b0; compute_en = 1'b0; clear_en = 1'b0; in_valid = 1'b0;
        read_load_en = 1'b0; read_base_in = 2'd0; ref_base_in = 2'd0;
        in1_up = '0; in2_diag = '0;
        #23;
        chk("rst_out1", int'(out1), 0);
        chk("rst_valid", int'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 5-row chain GAGCT vs AGCGT, one row at a time fed by the prior row.
        for (int r = 0; r < 5; r++) begin
            load_read(reads[r]);
            run_row(r, 1'b0);
        end

        // Same window again with stalls inserted must reproduce row 2 exactly.
        load_read(reads[2]);
        run_row(2, 1'b1);
        run_row(2, 1'b0);

        // Ties and zero floor.
        load_read(0);
        do_clear();
        step(1'b1, 1'b1, 1, 3, 2, 2, 2);
        do_clear();
        step(1'b1, 1'b1, 1, 0, 0, 0, 0);
        step(1'b1, 1'b1, 0, 4, 1, 3, 1);
        step(1'b1, 1'b1, 1, 3, 0, 2, 2);
        idle();

        // Saturation at 127.
        do_clear();
        step(1'b1, 1'b1, 0, 0, 127, 127, 1);
        step(1'b1, 1'b1, 0, 0, 127, 127, 1);
        step(1'b1, 1'b1, 0, 127, 126, 127, 1);
        idle();

        // Random mixed traffic against the model.
        for (int k = 0; k < 40; k++) begin
            if (k % 10 == 0) begin
                load_read(int'($urandom_range(0, 3)));
                do_clear();
            end
            step(1'b1, 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 40)), int'($urandom_range(0, 40)), -1, -1);
        end
        idle();
        idle();

        // Asynchronous reset mid-operation, with compute enabled but no valid data.
        step(1'b1, 1'b1, m_read, 20, 30, -1, -1);
        idle();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        m_read = 0; m_cur = 0; m_prev = 0;
        #1;
        chk("async_rst_out1", int'(out1), 0);
        chk("async_rst_out2", int'(out2), 0);
        chk("async_rst_dir", int'(dir), 0);
        chk("async_rst_valid", int'(out_valid), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_score", int'(pe_score), 0);
        chk("post_rst_valid", int'(out_valid), 0);

        // read_reg was cleared by reset: read A=0 matches ref A.
        step(1'b1, 1'b1, 0, 0, 5, 7, 1);
        idle();
        idle();

        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
